multi_fetch_gen: RTL

Parametrised N-wide front-end fetch stage: holds the fetch PC, reads a FETCH_WIDTH-instruction group from instruction memory, predecodes each slot for static branch prediction, truncates the group after the first predicted-taken slot, and registers the packet into a valid/ready output stage feeding the instruction buffer. Redirects from NUM_RESOLVE in-order resolve ports override all other activity. Saturating performance counters track delivered groups and redirects.

---
 rtl/multi_fetch_gen_if.sv | 27 ++
 rtl/multi_fetch_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multi_fetch_gen_if.sv
// Fetch packet channel from the fetch stage to the instruction buffer.
// Handshake: the stage presents a packet whenever any fetch_valid_o bit is
// set; the buffer takes the whole packet on a rising edge where
// fetch_ready_i is high. The packet holds steady while it waits for ready.
interface multi_fetch_gen_if #(
   parameter int FETCH_WIDTH = 4,
   parameter int XLEN        = 32
);
   logic [FETCH_WIDTH-1:0]      fetch_valid_o;
   logic                        fetch_ready_i;
   logic [FETCH_WIDTH*XLEN-1:0] fetch_pc_o;
   logic [FETCH_WIDTH*32-1:0]   fetch_inst_o;
   logic [FETCH_WIDTH-1:0]      fetch_pred_taken_o;
   logic [XLEN-1:0]             fetch_pred_target_o;

   modport master (
      output fetch_valid_o, fetch_pc_o, fetch_inst_o,
             fetch_pred_taken_o, fetch_pred_target_o,
      input  fetch_ready_i
   );

   modport slave (
      input  fetch_valid_o, fetch_pc_o, fetch_inst_o,
             fetch_pred_taken_o, fetch_pred_target_o,
      output fetch_ready_i
   );
endinterface

// File: rtl/multi_fetch_gen.sv
// N-wide fetch stage: holds the fetch PC, predecodes the instruction group
// returned by imem for static branch prediction (JAL and backward branches
// taken), cuts the group after the first taken slot and registers it into the
// output packet. Resolve-port redirects override everything else.
module multi_fetch_gen #(
   parameter int              FETCH_WIDTH    = 4,
   parameter int              NUM_RESOLVE    = 3,
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int              ALIGNED_GROUPS = 0,
   parameter int              CNT_W          = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [XLEN-1:0]               imem_addr_o,
   input  logic [FETCH_WIDTH*32-1:0]     imem_rdata_i,
   input  logic                          stall_i,
   input  logic [NUM_RESOLVE-1:0]        redirect_valid_i,
   input  logic [NUM_RESOLVE*XLEN-1:0]   redirect_pc_i,
   multi_fetch_gen_if.master             fetch,
   output logic [CNT_W-1:0]              perf_groups_o,
   output logic [CNT_W-1:0]              perf_redirects_o
);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [XLEN-1:0]        pc_q;
   logic [XLEN-1:0]        slot_pc  [FETCH_WIDTH];
   logic [XLEN-1:0]        slot_tgt [FETCH_WIDTH];
   logic [XLEN-1:0]        j_imm    [FETCH_WIDTH];
   logic [XLEN-1:0]        b_imm    [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] raw_valid;
   logic [FETCH_WIDTH-1:0] slot_taken;
   logic [XLEN-1:0]        grp_off;

   logic [FETCH_WIDTH-1:0]      grp_valid;
   logic [FETCH_WIDTH-1:0]      grp_taken;
   logic [XLEN-1:0]             grp_target;
   logic [FETCH_WIDTH*XLEN-1:0] grp_pc;
   logic [XLEN-1:0]             n_valid;
   logic                        found;
   logic [XLEN-1:0]             next_pc;

   logic                        any_redirect;
   logic [XLEN-1:0]             redirect_pc;
   logic                        out_busy;
   logic                        out_accept;
   logic                        advance;

   assign imem_addr_o = pc_q;

   // Per-slot PC, raw validity (alignment window) and static prediction.
   always_comb begin
      grp_off = (pc_q >> 2) & XLEN'(FETCH_WIDTH - 1);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         slot_pc[i] = pc_q + XLEN'(4 * i);
         j_imm[i] = {{(XLEN-20){imem_rdata_i[i*32+31]}},
                     imem_rdata_i[i*32+12 +: 8], imem_rdata_i[i*32+20],
                     imem_rdata_i[i*32+21 +: 10], 1'b0};
         b_imm[i] = {{(XLEN-12){imem_rdata_i[i*32+31]}},
                     imem_rdata_i[i*32+7], imem_rdata_i[i*32+25 +: 6],
                     imem_rdata_i[i*32+8 +: 4], 1'b0};
         if (ALIGNED_GROUPS != 0)
            raw_valid[i] = (grp_off + XLEN'(i)) < XLEN'(FETCH_WIDTH);
         else
            raw_valid[i] = 1'b1;
         slot_taken[i] = 1'b0;
         slot_tgt[i]   = '0;
         if (imem_rdata_i[i*32 +: 7] == OP_JAL) begin
            slot_taken[i] = 1'b1;
            slot_tgt[i]   = slot_pc[i] + j_imm[i];
         end else if (imem_rdata_i[i*32 +: 7] == OP_BRANCH) begin
            // Backward branches (negative offset) are predicted taken.
            slot_taken[i] = imem_rdata_i[i*32+31];
            slot_tgt[i]   = slot_pc[i] + b_imm[i];
         end
      end
   end

   // Truncate the group after the first taken slot and form the next PC.
   always_comb begin
      found      = 1'b0;
      grp_valid  = '0;
      grp_taken  = '0;
      grp_target = '0;
      grp_pc     = '0;
      n_valid    = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         grp_pc[i*XLEN +: XLEN] = slot_pc[i];
         if (raw_valid[i] && !found) begin
            grp_valid[i] = 1'b1;
            n_valid      = n_valid + XLEN'(1);
            if (slot_taken[i]) begin
               found        = 1'b1;
               grp_taken[i] = 1'b1;
               grp_target   = slot_tgt[i];
            end
         end
      end
      next_pc = found ? grp_target : pc_q + (n_valid << 2);
   end

   // Oldest (lowest-index) redirect wins; scanning downward lets it overwrite.
   always_comb begin
      any_redirect = |redirect_valid_i;
      redirect_pc  = '0;
      for (int j = NUM_RESOLVE - 1; j >= 0; j--) begin
         if (redirect_valid_i[j])
            redirect_pc = redirect_pc_i[j*XLEN +: XLEN];
      end
   end

   assign out_busy   = |fetch.fetch_valid_o;
   assign out_accept = out_busy & fetch.fetch_ready_i;
   assign advance    = ~stall_i & (~out_busy | fetch.fetch_ready_i);

   // PC and output packet: redirect squashes, otherwise capture or drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q                      <= RESET_PC;
         fetch.fetch_valid_o       <= '0;
         fetch.fetch_pc_o          <= '0;
         fetch.fetch_inst_o        <= '0;
         fetch.fetch_pred_taken_o  <= '0;
         fetch.fetch_pred_target_o <= '0;
      end else if (any_redirect) begin
         pc_q                      <= redirect_pc;
         fetch.fetch_valid_o       <= '0;
         fetch.fetch_pc_o          <= '0;
         fetch.fetch_inst_o        <= '0;
         fetch.fetch_pred_taken_o  <= '0;
         fetch.fetch_pred_target_o <= '0;
      end else if (advance) begin
         pc_q                      <= next_pc;
         fetch.fetch_valid_o       <= grp_valid;
         fetch.fetch_pc_o          <= grp_pc;
         fetch.fetch_inst_o        <= imem_rdata_i;
         fetch.fetch_pred_taken_o  <= grp_taken;
         fetch.fetch_pred_target_o <= grp_target;
      end else if (out_accept) begin
         fetch.fetch_valid_o       <= '0;
      end
   end

   // Saturating performance counters; a squashed packet is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_groups_o    <= '0;
         perf_redirects_o <= '0;
      end else begin
         if (out_accept && !any_redirect && perf_groups_o != '1)
            perf_groups_o <= perf_groups_o + CNT_W'(1);
         if (any_redirect && perf_redirects_o != '1)
            perf_redirects_o <= perf_redirects_o + CNT_W'(1);
      end
   end

endmodule
